// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and the bit-period divider,
// used by both the transmitter and the receiver so the two ends agree on the rate.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  function automatic int unsigned cycles_per_bit(input int unsigned clk_mhz,
                                                 input int unsigned baud);
    return (clk_mhz * 32'd1000000) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive buffer: power-of-two circular FIFO with one extra pointer bit
// to tell full from empty. Push and pop in the same cycle both take effect.
module uart_rx_fifo #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WIDTH      = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push at full still lands
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM, small
// receive FIFO, and sticky framing / overrun flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_MHZ    = 12,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx,
  output logic [7:0] recvData,
  output logic       recvValid,
  input  logic       recvAck,
  output logic       frameErr,
  output logic       overrun,
  input  logic       errClear
);

  localparam int unsigned CYCLES_PER_BIT = cycles_per_bit(CLK_MHZ, BAUD);
  localparam int unsigned HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int unsigned CW             = (CYCLES_PER_BIT > 2) ? $clog2(CYCLES_PER_BIT) : 1;

  logic            rx_meta;
  logic            rx_s;
  rx_state_t       state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            stop_done;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic            frame_evt;
  logic            overrun_evt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Stop-bit decisions are combinational so the FIFO and flags update on the
  // sample edge itself, making results visible the following cycle.
  assign stop_done   = (state == RX_STOP) && (cnt == '0);
  assign push        = stop_done && rx_s;
  assign frame_evt   = stop_done && !rx_s;
  assign pop         = recvAck && !fifo_empty;
  assign overrun_evt = push && fifo_full && !pop;
  assign recvValid   = !fifo_empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      frameErr <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      case (state)
        RX_IDLE: begin
          if (!rx_s) begin
            cnt   <= CW'(HALF_BIT - 1);
            state <= RX_START;
          end
        end
        RX_START: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (rx_s) begin
            state <= RX_IDLE;
          end else begin
            cnt     <= CW'(CYCLES_PER_BIT - 1);
            bit_idx <= '0;
            state   <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            shreg[bit_idx] <= rx_s;
            cnt            <= CW'(CYCLES_PER_BIT - 1);
            if (bit_idx == 3'd7) begin
              state <= RX_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        RX_STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= rx_s ? RX_IDLE : RX_BREAK;
          end
        end
        RX_BREAK: begin
          if (rx_s) begin
            state <= RX_IDLE;
          end
        end
        default: state <= RX_IDLE;
      endcase

      if (frame_evt) begin
        frameErr <= 1'b1;
      end else if (errClear) begin
        frameErr <= 1'b0;
      end

      if (overrun_evt) begin
        overrun <= 1'b1;
      end else if (errClear) begin
        overrun <= 1'b0;
      end
    end
  end

  uart_rx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (8)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (shreg),
    .pop       (pop),
    .head      (recvData),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus random frames, checked against a
// queue-based model of received bytes and sticky flags.
module tb_uart_rx;

  localparam int BIT_CYC = 104;
  localparam int DEPTH   = 4;

  logic       clk;
  logic       resetn;
  logic       rx;
  logic [7:0] recvData;
  logic       recvValid;
  logic       recvAck;
  logic       frameErr;
  logic       overrun;
  logic       errClear;

  int checks   = 0;
  int failures = 0;

  logic [7:0] q[$];
  bit         m_fe;
  bit         m_ov;

  uart_rx #(
    .CLK_MHZ    (12),
    .BAUD       (115200),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rx        (rx),
    .recvData  (recvData),
    .recvValid (recvValid),
    .recvAck   (recvAck),
    .frameErr  (frameErr),
    .overrun   (overrun),
    .errClear  (errClear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_valid"}, recvValid, (q.size() != 0));
    if (q.size() != 0) check({tag, "_data"}, recvData, q[0]);
    check({tag, "_ferr"}, frameErr, m_fe);
    check({tag, "_ovr"}, overrun, m_ov);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one full frame starting at the current cycle; leaves rx at the stop level.
  // The receiver's stop sample lands 55 cycles into the stop bit.
  task automatic send_frame(input logic [7:0] d, input bit stop, input bit ack);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int b = 0; b < 9; b++) begin
      rx = bits[b];
      repeat (BIT_CYC) @(posedge clk);
      #1;
    end
    rx = stop;
    repeat (54) @(posedge clk);
    #1;
    check("pre_valid", recvValid, (q.size() != 0));
    check("pre_ferr", frameErr, m_fe);
    check("pre_ovr", overrun, m_ov);
    if (ack) begin
      check("ack_head", recvData, q[0]);
      recvAck = 1'b1;
    end
    @(posedge clk);
    #1;
    recvAck = 1'b0;
    if (ack) q.delete(0);
    if (!stop) m_fe = 1'b1;
    else if (q.size() < DEPTH) q.push_back(d);
    else m_ov = 1'b1;
    check_state("post");
    repeat (BIT_CYC - 55) @(posedge clk);
    #1;
  endtask

  task automatic do_pop();
    check("pop_valid", recvValid, (q.size() != 0));
    recvAck = 1'b1;
    @(posedge clk);
    #1;
    recvAck = 1'b0;
    if (q.size() != 0) q.delete(0);
    check_state("after_pop");
  endtask

  task automatic err_clear();
    errClear = 1'b1;
    @(posedge clk);
    #1;
    errClear = 1'b0;
    m_fe = 1'b0;
    m_ov = 1'b0;
    check_state("clear");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq[5];
    resetn   = 1'b0;
    rx       = 1'b1;
    recvAck  = 1'b0;
    errClear = 1'b0;
    m_fe     = 1'b0;
    m_ov     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", recvData, 8'h00);
    check_state("rst");
    resetn = 1'b1;
    idle(5);

    // Single byte, exact visibility timing checked inside send_frame
    send_frame(8'hA5, 1'b1, 1'b0);
    check("a5_data", recvData, 8'hA5);
    idle(3);
    do_pop();
    do_pop();

    // Short low pulse must not be taken as a start bit
    rx = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    idle(100);
    check_state("glitch");
    idle(1100);
    check_state("glitch_late");

    // Framing error followed by a long break
    send_frame(8'h3C, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (250) @(posedge clk);
    #1;
    check_state("break_mid");
    repeat (250) @(posedge clk);
    #1;
    idle(1100);
    check_state("break_after");
    err_clear();
    send_frame(8'h11, 1'b1, 1'b0);
    idle(4);
    do_pop();

    // Overrun: fifth byte dropped
    seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    for (int i = 0; i < 5; i++) send_frame(seq[i], 1'b1, 1'b0);
    check("ovr_flag", overrun, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("ovr_order", recvData, seq[i]);
      do_pop();
    end
    check("ovr_empty", recvValid, 1'b0);
    err_clear();

    // Push and pop on the same cycle at full
    for (int i = 0; i < 4; i++) send_frame(8'(8'hA0 + i), 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b1);
    check("simul_ovr", overrun, 1'b0);
    check("simul_cnt", q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) check("simul_last", recvData, 8'h55);
      do_pop();
    end

    // Ack while empty is ignored
    do_pop();

    // Reset during data bit 4 of 8'hFF, with a byte already buffered
    send_frame(8'h99, 1'b1, 1'b0);
    rx = 1'b0;
    repeat (BIT_CYC) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (4 * BIT_CYC + 50) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    q.delete();
    m_fe = 1'b0;
    m_ov = 1'b0;
    check("rst2_data", recvData, 8'h00);
    check_state("rst2");
    repeat (5) @(posedge clk);
    #1;
    check_state("rst2_hold");
    resetn = 1'b1;
    idle(BIT_CYC * 4);
    check_state("rst2_idle");
    send_frame(8'h42, 1'b1, 1'b0);
    idle(4);
    check("rst2_only", q.size(), 1);
    do_pop();

    // Random traffic
    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      bit         stop;
      bit         ack;
      d    = 8'($urandom);
      stop = ($urandom_range(0, 6) != 0);
      ack  = (q.size() != 0) && ($urandom_range(0, 3) == 0);
      send_frame(d, stop, ack);
      idle($urandom_range(4, 30));
      for (int p = $urandom_range(0, 2); p > 0; p--) do_pop();
      if ($urandom_range(0, 4) == 0) err_clear();
    end
    while (q.size() != 0) do_pop();
    check_state("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver, the counterpart of the SoC's `uart` transmitter. It deserialises 8N1 frames from the `rx` pin and buffers received bytes in a 4-entry FIFO. It reports framing and overrun errors. It sits beside `uart0` in `soc`, and cores read it through the memory-mapped I/O decode at `mem_addr_high == 4'h2`.

## Interface
Parameters:
- `CLK_MHZ`, default 12: system clock frequency in MHz.
- `BAUD`, default 115200: line rate in bit/s.
- `FIFO_DEPTH`, default 4: receive buffer entries; must be a power of two, at least 2.

Ports:
- `clk`, input, 1: the single clock. All logic is on its rising edge.
- `resetn`, input, 1: reset, asynchronous and active-low.
- `rx`, input, 1: serial line, asynchronous to `clk`, idle high.
- `recvData`, output, 8: byte at the FIFO head; only meaningful while `recvValid` is high.
- `recvValid`, output, 1: FIFO not empty.
- `recvAck`, input, 1: pop the head entry; ignored when `recvValid` is low.
- `frameErr`, output, 1: sticky flag; a stop bit was sampled low.
- `overrun`, output, 1: sticky flag; a byte completed while the FIFO was full, and that byte was dropped.
- `errClear`, input, 1: pulse that clears both sticky flags.

## Operation
- `CYCLES_PER_BIT = CLK_MHZ*1000000/BAUD`, with integer truncation; this is 104 at the defaults. `HALF_BIT = CYCLES_PER_BIT/2`.
- Synchroniser: `rx` passes through 2 flops, reset to 1. The FSM uses only the synchronised value, `rxS`.
- FSM states and transitions:
  - IDLE: on `rxS == 0`, load the bit counter with `HALF_BIT-1` and go to START.
  - START: when the counter reaches 0, resample. If `rxS == 1`, the start bit was a glitch; return to IDLE with no flag. If `rxS == 0`, load `CYCLES_PER_BIT-1` and go to DATA with bit index 0.
  - DATA: each time the counter expires, shift `rxS` into bit [index]. Bits arrive LSB first. After index 7, go to STOP.
  - STOP: when the counter expires, sample `rxS`.
    - If 1: push the byte, or set `overrun` if the FIFO is full. Go to IDLE.
    - If 0: set `frameErr`, discard the byte, go to BREAK.
  - BREAK: wait for `rxS == 1`, then go to IDLE. This prevents a held-low line from re-triggering start detection.
- FIFO pointers: read and write pointers are `log2(FIFO_DEPTH)+1` bits wide. Empty when the pointers are equal; full when the MSBs differ and the low bits are equal. Pointers wrap naturally.
- Push while full with no pop in the same cycle: the byte is dropped, `overrun` is set, and FIFO contents are unchanged.
- Push and pop in the same cycle: both take effect. Occupancy is unchanged and no overrun is raised, even when full.
- `errClear` in the same cycle as a new error event: the set wins and the flag stays 1.

## Timing
- Reset values: FSM in IDLE, FIFO empty, `recvValid=0`, `recvData=8'h00`, `frameErr=0`, `overrun=0`, synchroniser flops at 1.
- Reset asserted mid-frame: the partial byte is lost, and the FSM restarts in IDLE after release.
- Latency from `rx` falling edge to start detection: 2 cycles (synchroniser) plus 1 cycle (FSM).
- Sample points: the start bit is confirmed `HALF_BIT` cycles after detection. Data bit n is sampled `(n+1)*CYCLES_PER_BIT` cycles after that confirmation, and the stop bit at `9*CYCLES_PER_BIT`.
- Byte and flag visibility: `recvValid` rises, and the new byte appears on `recvData` when the FIFO was empty, on the cycle after the stop-bit sample. `frameErr` and `overrun` also rise on that cycle.
- Pop: `recvAck` sampled high with `recvValid` high advances the head. The next entry, or `recvValid=0`, is visible the following cycle.
- All outputs are registered or decoded directly from registered state. There is no combinational path from `rx`, `recvAck` or `errClear` to any output.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state encodings (IDLE, START, DATA, STOP, BREAK);
  - a `cycles_per_bit(CLK_MHZ, BAUD)` function.
- The transmitter computes its divider with the same `cycles_per_bit` function, so both ends agree on the rate.
- Sub-module `uart_rx_fifo`: parameterised by `FIFO_DEPTH`, with push/pop/full/empty ports. It is the natural unit for standalone verification.

## Test plan
All scenarios use the defaults (104 cycles/bit).
- Receive 8'hA5: drive the frame 0,1,0,1,0,0,1,0,1,1 at 104 cycles/bit. Required: `recvValid=1` and `recvData=8'hA5` the cycle after the stop sample; `frameErr=0`.
- Glitch rejection: drive `rx` low for 30 cycles, then high. Required: the FSM returns to IDLE, `recvValid` stays 0, and no flag is set.
- Framing error: send 8'h3C with the stop bit driven 0, then hold `rx` low for 500 cycles, then release high. Required: `frameErr=1`, FIFO still empty, no new start detected until after the release; a following 8'h11 frame is received correctly.
- Overrun: send 8'h01 through 8'h05 back-to-back with no ack. Required: `overrun=1`; pops yield 01, 02, 03, 04, then `recvValid=0`.
- Simultaneous push and pop at full: fill with 4 bytes, then assert `recvAck` on the exact cycle the 5th byte (8'h55) is pushed. Required: no overrun, the FIFO holds 4 entries, and 8'h55 is the last one popped.
- Reset mid-frame: assert `resetn=0` during data bit 4 of 8'hFF, then release and send 8'h42. Required: all outputs are at their reset values during reset; only 8'h42 is received afterwards.
